// File: rtl/clk_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_div_ctrl                                                 |
// | Description : Run-time programmable, glitch-free clock-divider controller. |
// |               Generates out_clk = clk / D from a registered counter and    |
// |               starts, stops and re-programs it only on period boundaries.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   1      input clock, all state updates on posedge         |
// |   rst_n      in   1      asynchronous active-low reset                     |
// |   en         in   1      run request (sampled in STOP / at boundary)       |
// |   cfg_valid  in   1      new ratio offered on cfg_div                      |
// |   cfg_div    in   DIV_W  requested divide ratio D                          |
// |   cfg_ready  out  1      no ratio pending; handshake on valid & ready      |
// |   cfg_err    out  1      1-cycle pulse: accepted ratio was < 2, dropped    |
// |   out_clk    out  1      divided clock, straight from a flop               |
// |   out_tick   out  1      1-cycle pulse with every out_clk rising edge      |
// |   cur_div    out  DIV_W  ratio currently in effect                         |
// |   active     out  1      high while the divider is running                 |
// +----------------------------------------------------------------------------+
module clk_div_ctrl #(
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             out_clk,
    output logic             out_tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             active
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0]       c_ST_STOP   = 1'b0;
    localparam logic [0:0]       c_ST_RUN    = 1'b1;
    localparam logic [DIV_W-1:0] c_RESET_DIV = DIV_W'(RESET_DIV);
    localparam logic [DIV_W-1:0] c_ZERO      = '0;
    localparam logic [DIV_W-1:0] c_ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_TWO       = DIV_W'(2);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic             r_out_clk;
    logic             r_tick;
    logic             r_active;
    logic [DIV_W-1:0] r_cur_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_cfg_ready;
    logic             r_cfg_err;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic             w_last;       // counter sits on the last cycle of a period
    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W:0]   w_half;       // high-phase length H = (D+1)>>1
    logic             w_high_next;  // out_clk level for the next counter value
    logic             w_cfg_fire;
    logic             w_cfg_bad;
    logic             w_apply;      // pending ratio becomes current this edge

    assign w_last    = (r_cnt == (r_cur_div - c_ONE));
    assign w_cnt_inc = r_cnt + c_ONE;

    // One extra bit keeps D = 2**DIV_W-1 from wrapping when rounding up.
    assign w_half      = ({1'b0, r_cur_div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    assign w_high_next = ({1'b0, w_cnt_inc} < w_half);

    assign w_cfg_fire = cfg_valid & r_cfg_ready;
    assign w_cfg_bad  = (cfg_div < c_TWO);

    // A pending ratio may only take effect while stopped or on the edge that
    // closes a period, so the period that follows is always built from one D.
    // In STOP the counter is 0 and D >= 2, so w_last is never true there.
    assign w_apply = r_pend & ((r_state == c_ST_STOP) | w_last);

    // ------------------------------------------------------------------------
    // Divider sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_STOP;
            r_cnt     <= c_ZERO;
            r_out_clk <= 1'b0;
            r_tick    <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_STOP: begin
                    r_cnt <= c_ZERO;
                    if (en) begin
                        // Launch a full period: rising edge happens right here.
                        r_state   <= c_ST_RUN;
                        r_out_clk <= 1'b1;
                        r_tick    <= 1'b1;
                        r_active  <= 1'b1;
                    end else begin
                        r_out_clk <= 1'b0;
                        r_tick    <= 1'b0;
                        r_active  <= 1'b0;
                    end
                end

                c_ST_RUN: begin
                    if (!w_last) begin
                        // Mid-period: en is deliberately ignored so that a
                        // stop request can never shorten the current pulse.
                        r_cnt     <= w_cnt_inc;
                        r_out_clk <= w_high_next;
                        r_tick    <= 1'b0;
                    end else begin
                        r_cnt <= c_ZERO;
                        if (en) begin
                            r_out_clk <= 1'b1;
                            r_tick    <= 1'b1;
                        end else begin
                            // out_clk is already low in the last cycle, so
                            // stopping here leaves no partial pulse behind.
                            r_state   <= c_ST_STOP;
                            r_out_clk <= 1'b0;
                            r_tick    <= 1'b0;
                            r_active  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state   <= c_ST_STOP;
                    r_cnt     <= c_ZERO;
                    r_out_clk <= 1'b0;
                    r_tick    <= 1'b0;
                    r_active  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Ratio configuration: single-entry holding register
    // ------------------------------------------------------------------------
    // Accept and apply are mutually exclusive: accept needs r_pend == 0 while
    // apply needs r_pend == 1, so one edge never does both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_div   <= c_RESET_DIV;
            r_pend_div  <= c_RESET_DIV;
            r_pend      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;

            if (w_cfg_fire) begin
                if (w_cfg_bad) begin
                    // Ratios 0 and 1 cannot produce a low phase; drop them and
                    // flag the requester, the slot stays free.
                    r_cfg_err <= 1'b1;
                end else begin
                    r_pend_div  <= cfg_div;
                    r_pend      <= 1'b1;
                    r_cfg_ready <= 1'b0;
                end
            end

            if (w_apply) begin
                r_cur_div   <= r_pend_div;
                r_pend      <= 1'b0;
                r_cfg_ready <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven directly from flops)
    // ------------------------------------------------------------------------
    assign out_clk   = r_out_clk;
    assign out_tick  = r_tick;
    assign active    = r_active;
    assign cur_div   = r_cur_div;
    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
